// File: rtl/if_fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, talks to a variable-latency req/ack
// instruction memory and buffers {pc,instr} pairs in a small queue for ID.
module if_fetch_queue #(
  parameter int unsigned         ADDR_W   = 32,
  parameter int unsigned         INSTR_W  = 32,
  parameter logic [ADDR_W-1:0]   RESET_PC = {ADDR_W{1'b0}},
  parameter int unsigned         QDEPTH   = 4,
  parameter logic [INSTR_W-1:0]  NOP      = {INSTR_W{1'b0}}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               load_fwd_stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_address,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  PC,
  output logic               valid
);

  localparam int unsigned     PTR_W   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned     CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QDEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_req, w_req_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [ADDR_W-1:0]   r_fpc, w_fpc_nxt;
  logic [ADDR_W-1:0]   w_fpc_inc, w_target;
  logic [ADDR_W-1:0]   r_q_pc    [QDEPTH];
  logic [INSTR_W-1:0]  r_q_instr [QDEPTH];
  logic [PTR_W-1:0]    r_rd_ptr, r_wr_ptr;
  logic [CNT_W-1:0]    r_count, w_count_nxt;
  logic                w_push, w_pop, w_valid;

  assign w_fpc_inc = r_fpc + ADDR_W'(32'd4);
  assign w_target  = branch_address & {{(ADDR_W-2){1'b1}}, 2'b00};
  assign w_valid   = (r_count != {CNT_W{1'b0}});
  assign w_pop     = w_valid & ~stall & ~load_fwd_stall & ~branch_taken;
  // Only data for a request still in WAIT is kept; a redirect in the same cycle wins.
  assign w_push    = (r_state == S_WAIT) & imem_ack & ~branch_taken;

  always_comb begin
    w_count_nxt = r_count;
    if (branch_taken) begin
      w_count_nxt = {CNT_W{1'b0}};
    end else if (w_push && !w_pop) begin
      w_count_nxt = r_count + CNT_W'(1'b1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CNT_W'(1'b1);
    end else begin
      w_count_nxt = r_count;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_addr  <= RESET_PC;
      r_fpc   <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
      r_addr  <= w_addr_nxt;
      r_fpc   <= w_fpc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (branch_taken)           w_state_nxt = S_IDLE;
        else if (r_count < DEPTH_C) w_state_nxt = S_WAIT;
        else                        w_state_nxt = S_IDLE;
      end
      S_WAIT: begin
        if (branch_taken)  w_state_nxt = imem_ack ? S_WAIT : S_DISCARD;
        else if (imem_ack) w_state_nxt = (w_count_nxt < DEPTH_C) ? S_WAIT : S_IDLE;
        else               w_state_nxt = S_WAIT;
      end
      S_DISCARD: begin
        if (imem_ack) w_state_nxt = S_IDLE;
        else          w_state_nxt = S_DISCARD;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next request/address/fetch-PC; at most one request is ever outstanding.
  always_comb begin
    w_req_nxt  = r_req;
    w_addr_nxt = r_addr;
    w_fpc_nxt  = r_fpc;
    case (r_state)
      S_IDLE: begin
        if (branch_taken) begin
          w_req_nxt = 1'b0;
          w_fpc_nxt = w_target;
        end else if (r_count < DEPTH_C) begin
          w_req_nxt  = 1'b1;
          w_addr_nxt = r_fpc;
        end else begin
          w_req_nxt = 1'b0;
        end
      end
      S_WAIT: begin
        if (branch_taken) begin
          w_fpc_nxt = w_target;
          w_req_nxt = 1'b1;
          if (imem_ack) w_addr_nxt = w_target;
          else          w_addr_nxt = r_addr;
        end else if (imem_ack) begin
          w_fpc_nxt = w_fpc_inc;
          if (w_count_nxt < DEPTH_C) begin
            w_req_nxt  = 1'b1;
            w_addr_nxt = w_fpc_inc;
          end else begin
            w_req_nxt = 1'b0;
          end
        end else begin
          w_req_nxt = 1'b1;
        end
      end
      S_DISCARD: begin
        if (branch_taken) w_fpc_nxt = w_target;
        else              w_fpc_nxt = r_fpc;
        if (imem_ack) w_req_nxt = 1'b0;
        else          w_req_nxt = 1'b1;
      end
      default: begin
        w_req_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= {PTR_W{1'b0}};
      r_wr_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      r_count <= w_count_nxt;
      if (branch_taken) begin
        r_rd_ptr <= r_wr_ptr;
      end else begin
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1'b1);
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1'b1);
      end
    end
  end

  // Queue payload needs no reset: it is only read when the count says it is live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_wr_ptr]    <= r_fpc;
      r_q_instr[r_wr_ptr] <= imem_rdata;
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_addr;
  assign valid       = w_valid;
  assign instruction = w_valid ? r_q_instr[r_rd_ptr] : NOP;
  assign PC          = w_valid ? (r_q_pc[r_rd_ptr] + ADDR_W'(32'd4)) : {ADDR_W{1'b0}};

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomised bench for if_fetch_queue: a 32-bit/depth-4 and an 8-bit/depth-2 instance
// share control inputs, each with its own memory responder and queue-based reference model.
module tb_if_fetch_queue;

  localparam int NI = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst, stall, lfs, br;
  logic [31:0] baddr;
  logic        a_req, a_ack, a_valid;
  logic [31:0] a_addr, a_rdata, a_instr, a_pc;
  logic        b_req, b_ack, b_valid;
  logic [7:0]  b_addr, b_pc;
  logic [31:0] b_rdata, b_instr;

  always #5 clk = ~clk;

  if_fetch_queue #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0), .QDEPTH(4), .NOP(32'h0)) u_dut_a (
    .clk(clk), .rst(rst), .stall(stall), .load_fwd_stall(lfs), .branch_taken(br),
    .branch_address(baddr), .imem_req(a_req), .imem_addr(a_addr), .imem_ack(a_ack),
    .imem_rdata(a_rdata), .instruction(a_instr), .PC(a_pc), .valid(a_valid));

  if_fetch_queue #(.ADDR_W(8), .INSTR_W(32), .RESET_PC(8'hF0), .QDEPTH(2), .NOP(32'h0000_0013)) u_dut_b (
    .clk(clk), .rst(rst), .stall(stall), .load_fwd_stall(lfs), .branch_taken(br),
    .branch_address(baddr[7:0]), .imem_req(b_req), .imem_addr(b_addr), .imem_ack(b_ack),
    .imem_rdata(b_rdata), .instruction(b_instr), .PC(b_pc), .valid(b_valid));

  ent_t        mq [NI][$];
  logic [31:0] m_next [NI], req_addr [NI], prev_issue [NI];
  logic [31:0] mask [NI], rpc [NI], nop [NI];
  int          depth [NI], lat [NI], minlat [NI], maxlat [NI], gap [NI], pops [NI];
  bit          busy [NI], stale [NI], new_req [NI];
  bit          wrap_seen;
  int          n_checks, n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  function automatic logic g_req(input int k);
    return (k == 0) ? a_req : b_req;
  endfunction
  function automatic logic g_valid(input int k);
    return (k == 0) ? a_valid : b_valid;
  endfunction
  function automatic logic [31:0] g_addr(input int k);
    return (k == 0) ? a_addr : {24'h0, b_addr};
  endfunction
  function automatic logic [31:0] g_instr(input int k);
    return (k == 0) ? a_instr : b_instr;
  endfunction
  function automatic logic [31:0] g_pc(input int k);
    return (k == 0) ? a_pc : {24'h0, b_pc};
  endfunction

  task automatic set_lat(input int lo, input int hi);
    for (int k = 0; k < NI; k++) begin
      minlat[k] = lo;
      maxlat[k] = hi;
    end
  endtask

  // Post-edge: compare head outputs with the model and track the request handshake.
  task automatic post();
    for (int k = 0; k < NI; k++) begin
      if (mq[k].size() > 0) begin
        chk("valid", {31'h0, g_valid(k)}, 32'd1);
        chk("instr", g_instr(k), mq[k][0].ins);
        chk("pc", g_pc(k), (mq[k][0].pc + 32'd4) & mask[k]);
      end else begin
        chk("valid", {31'h0, g_valid(k)}, 32'd0);
        chk("instr_nop", g_instr(k), nop[k]);
        chk("pc_zero", g_pc(k), 32'd0);
      end
      new_req[k] = 1'b0;
      if (busy[k]) begin
        chk("req_hold", {31'h0, g_req(k)}, 32'd1);
        chk("addr_stable", g_addr(k), req_addr[k]);
      end else if (g_req(k)) begin
        new_req[k]  = 1'b1;
        busy[k]     = 1'b1;
        stale[k]    = 1'b0;
        req_addr[k] = g_addr(k);
        lat[k]      = $urandom_range(maxlat[k], minlat[k]);
        chk("issue_addr", g_addr(k), m_next[k]);
        if (k == 1 && g_addr(k) == 32'h0 && prev_issue[k] == 32'hFC) wrap_seen = 1'b1;
        prev_issue[k] = g_addr(k);
      end
      if (!g_req(k) && mq[k].size() < depth[k]) gap[k]++;
      else gap[k] = 0;
      chk("req_gap", {31'h0, gap[k] <= 2}, 32'd1);
      if (gap[k] > 2) gap[k] = 0;
    end
  endtask

  // One clock: drive memory acks, let the edge happen, advance the model, then check.
  task automatic cycle();
    logic        pre_ack [NI];
    logic        pre_st, pre_lfs, pre_br;
    logic [31:0] pre_baddr;
    int          pre_size;
    bit          do_pop;
    for (int k = 0; k < NI; k++) pre_ack[k] = busy[k] && lat[k] == 0;
    a_ack   = pre_ack[0];
    a_rdata = pre_ack[0] ? mem_word(req_addr[0]) : 32'hDEAD_BEEF;
    b_ack   = pre_ack[1];
    b_rdata = pre_ack[1] ? mem_word(req_addr[1]) : 32'hDEAD_BEEF;
    pre_st = stall; pre_lfs = lfs; pre_br = br; pre_baddr = baddr;
    @(posedge clk);
    for (int k = 0; k < NI; k++) begin
      pre_size = mq[k].size();
      do_pop   = pre_size > 0 && !pre_st && !pre_lfs && !pre_br;
      if (do_pop) begin
        void'(mq[k].pop_front());
        pops[k]++;
      end
      if (pre_ack[k]) begin
        if (!stale[k] && !pre_br) begin
          chk("no_overflow", {31'h0, (pre_size - (do_pop ? 1 : 0)) < depth[k]}, 32'd1);
          mq[k].push_back('{pc: req_addr[k], ins: mem_word(req_addr[k])});
          m_next[k] = (m_next[k] + 32'd4) & mask[k];
        end
        busy[k] = 1'b0;
      end else if (busy[k]) begin
        lat[k]--;
      end
      if (pre_br) begin
        mq[k].delete();
        m_next[k] = pre_baddr & mask[k] & 32'hFFFF_FFFC;
        if (busy[k]) stale[k] = 1'b1;
        gap[k] = 0;
      end
    end
    #1;
    post();
  endtask

  task automatic do_reset(input int hold);
    stall = 1'b0; lfs = 1'b0; br = 1'b0;
    a_ack = 1'b0; b_ack = 1'b0;
    rst = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk("rst_req", {31'h0, g_req(k)}, 32'd0);
      chk("rst_valid", {31'h0, g_valid(k)}, 32'd0);
      chk("rst_instr", g_instr(k), nop[k]);
      chk("rst_pc", g_pc(k), 32'd0);
      mq[k].delete();
      busy[k] = 1'b0; stale[k] = 1'b0; gap[k] = 0;
      m_next[k] = rpc[k];
    end
    repeat (hold) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    post();
  endtask

  initial begin
    int n;
    mask[0] = 32'hFFFF_FFFF; rpc[0] = 32'h0;  nop[0] = 32'h0;         depth[0] = 4;
    mask[1] = 32'h0000_00FF; rpc[1] = 32'hF0; nop[1] = 32'h0000_0013; depth[1] = 2;
    for (int k = 0; k < NI; k++) begin
      pops[k] = 0; prev_issue[k] = 32'hFFFF_FFFF; lat[k] = 0;
    end
    n_checks = 0; n_fail = 0; wrap_seen = 1'b0;
    rst = 1'b1; stall = 1'b0; lfs = 1'b0; br = 1'b0; baddr = 32'h0;
    a_ack = 1'b0; b_ack = 1'b0; a_rdata = 32'h0; b_rdata = 32'h0;
    #2;

    // T1: reset while a request is outstanding
    set_lat(10, 10);
    do_reset(2);
    repeat (3) cycle();
    chk("t1_busy_before_rst", {31'h0, a_req}, 32'd1);
    set_lat(0, 0);
    do_reset(1);
    chk("t1_first_req", {31'h0, a_req}, 32'd1);
    chk("t1_first_addr", a_addr, 32'h0);

    // T2: zero-wait memory streams one instruction per clock
    for (int w = 0; w < 10 && !a_valid; w++) cycle();
    chk("t2_start", {31'h0, a_valid}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      chk("t2_valid", {31'h0, a_valid}, 32'd1);
      chk("t2_pc_seq", a_pc, 32'd4 * (i + 1));
      cycle();
    end

    // T3: long stall fills the queue, then exactly QDEPTH entries drain
    stall = 1'b1;
    repeat (10) cycle();
    chk("t3_req_off", {31'h0, a_req}, 32'd0);
    set_lat(15, 15);
    stall = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (a_valid) n++;
      cycle();
    end
    chk("t3_entries", n, 32'd4);

    // T4: redirect while waiting; in-flight data must be discarded
    set_lat(4, 4);
    for (int w = 0; w < 40 && !new_req[0]; w++) cycle();
    chk("t4_req_seen", {31'h0, new_req[0]}, 32'd1);
    br = 1'b1; baddr = 32'h0000_0103;
    cycle();
    br = 1'b0;
    for (int w = 0; w < 30 && !new_req[0]; w++) cycle();
    chk("t4_redirect_req", {31'h0, new_req[0]}, 32'd1);
    chk("t4_redirect_addr", a_addr, 32'h0000_0100);
    set_lat(0, 0);
    for (int w = 0; w < 20 && !a_valid; w++) cycle();
    chk("t4_head_pc", a_pc, 32'h0000_0104);
    chk("t4_head_instr", a_instr, mem_word(32'h0000_0100));

    // T5: branch coincides with ack and a would-be pop
    for (int w = 0; w < 20 && !(a_valid && busy[0] && !stale[0] && lat[0] == 0); w++) cycle();
    chk("t5_setup", {31'h0, a_valid && busy[0] && lat[0] == 0}, 32'd1);
    br = 1'b1; baddr = 32'h0000_0200;
    cycle();
    br = 1'b0;
    chk("t5_flushed", {31'h0, a_valid}, 32'd0);
    chk("t5_req", {31'h0, a_req}, 32'd1);
    chk("t5_addr", a_addr, 32'h0000_0200);
    cycle();
    chk("t5_first_pc", a_pc, 32'h0000_0204);

    // T6 plus general random traffic, random memory latency 0-5
    set_lat(0, 5);
    for (int i = 0; i < 1500; i++) begin
      stall = ($urandom_range(99, 0) < 20);
      lfs   = ($urandom_range(99, 0) < 10);
      br    = ($urandom_range(99, 0) < 4);
      baddr = ($urandom_range(3, 0) == 0) ? 32'h0000_00F4 : $urandom;
      if (i == 700) do_reset(1);
      else cycle();
    end
    stall = 1'b0; lfs = 1'b0; br = 1'b0;
    repeat (5) cycle();
    chk("t6_wrap_seen", {31'h0, wrap_seen}, 32'd1);
    chk("t6_b_pops", {31'h0, pops[1] >= 20}, 32'd1);
    chk("a_pops", {31'h0, pops[0] >= 50}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
